alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational `alu` instance between two requesters: requester 0 is the execute stage and requester 1 is the branch/compare unit.
- Arbitration is round-robin with valid/ready handshakes on both the request and response sides.
- The ALU output is captured in a one-entry response register tagged with the requester ID.
- Sits between the decode/execute control logic and the `alu` datapath.

Parameters:
- DATA_W, 32, operand/result width; must match the `alu` operand width.
- CTRL_W, 4, ALU control width; encodings come from rtl/parameters.vh (`ADD, `SUB, `EQ, ...).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_req0_valid  input  1  requester 0 has an operation pending.
- o_req0_ready  output  1  requester 0 operation accepted this cycle (the grant).
- i_req0_op1  input  DATA_W  requester 0 operand 1.
- i_req0_op2  input  DATA_W  requester 0 operand 2.
- i_req0_ctrl  input  CTRL_W  requester 0 ALU control.
- i_req1_valid, o_req1_ready, i_req1_op1, i_req1_op2, i_req1_ctrl: same widths and meanings, for requester 1.
- o_alu_op1  output  DATA_W  to `alu` i_op1.
- o_alu_op2  output  DATA_W  to `alu` i_op2.
- o_alu_ctrl  output  CTRL_W  to `alu` i_alu_ctrl.
- i_alu_result  input  DATA_W  from `alu` o_result.
- o_rsp_valid  output  1  response register holds a result.
- o_rsp_id  output  1  requester that owns the response (0 or 1).
- o_rsp_result  output  DATA_W  registered ALU result.
- i_rsp0_ready  input  1  requester 0 consumes its response.
- i_rsp1_ready  input  1  requester 1 consumes its response.

Behaviour:
- Reset (asynchronous, immediate): o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, priority pointer=0 (requester 0 favoured). o_reqN_ready is combinational and therefore 0 while held in reset.
- Response drain: rsp_drain = o_rsp_valid & (o_rsp_id ? i_rsp1_ready : i_rsp0_ready).
- Slot free: slot_free = !o_rsp_valid | rsp_drain. The same-cycle drain-and-refill path is mandatory, giving full throughput of one operation per cycle.
- Grant (combinational), only when slot_free:
  - Only req0 valid -> grant 0.
  - Only req1 valid -> grant 1.
  - Both valid -> grant goes to the requester named by the priority pointer.
  - Neither valid -> no grant.
- o_reqN_ready = grant to N. At most one ready is high per cycle.
- ALU mux: o_alu_op1/op2/ctrl are driven from the granted requester. With no grant, the mux select defaults to requester 0 fields; the result is ignored.
- On a grant edge: o_rsp_result <= i_alu_result, o_rsp_id <= granted index, o_rsp_valid <= 1, priority pointer <= ~granted index.
- On a drain with no new grant: o_rsp_valid <= 0. o_rsp_result and o_rsp_id hold their values.
- Latency: request accepted in cycle T -> response visible in cycle T+1.
- While o_rsp_valid=1 and undrained, both readys stay 0 and the response outputs stay stable.
- Requester rules:
  - Requesters must hold valid and payload stable until ready.
  - Dropping valid before ready is legal; the request is simply withdrawn, nothing is captured and the pointer does not change.
- Response-side ready of the requester that does not own the response is ignored.
- Priority pointer changes only on a grant. A lone requester granted repeatedly keeps the pointer pointing at the other requester.
- Reset mid-operation: a pending response is discarded and no grant is issued while i_rst=1.
- No arithmetic is performed here; widths pass through unchanged.

Test Plan:
- Reset released, req0 valid with op1=5, op2=3, ctrl=`ADD, i_rsp0_ready=1 -> o_req0_ready=1 in cycle T; in cycle T+1 o_rsp_valid=1, o_rsp_id=0, o_rsp_result=8.
- Both valid every cycle: req0 `SUB 10-4, req1 `EQ 7==7, both rsp readys=1 -> grants alternate 0,1,0,1 starting with 0; results alternate 6 and 1 with matching o_rsp_id. One grant per cycle.
- Backpressure: response held with i_rsp0_ready=0 for 3 cycles while req1 is valid -> both readys=0 and the response is stable. When i_rsp0_ready=1, req1 is granted in that same cycle and its response follows in the next cycle.
- Lone requester: only req1 valid for 4 cycles, then req0 also valid -> req1 is granted 4 times; in the contention cycle req0 wins (pointer=0).
- Withdrawal: req0 valid for 1 cycle while the slot is busy, then dropped -> no capture and the pointer is unchanged.
- Reset asserted while o_rsp_valid=1 -> o_rsp_valid=0, o_rsp_result=0 and readys=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage
// (requester 0) and the branch/compare unit (requester 1). Results are held in a
// one-entry response register that is tagged with the owning requester.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_op1,
  input  logic [DATA_W-1:0] i_req0_op2,
  input  logic [CTRL_W-1:0] i_req0_ctrl,

  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_op1,
  input  logic [DATA_W-1:0] i_req1_op2,
  input  logic [CTRL_W-1:0] i_req1_ctrl,

  output logic [DATA_W-1:0] o_alu_op1,
  output logic [DATA_W-1:0] o_alu_op2,
  output logic [CTRL_W-1:0] o_alu_ctrl,
  input  logic [DATA_W-1:0] i_alu_result,

  output logic              o_rsp_valid,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_rsp_result,
  input  logic              i_rsp0_ready,
  input  logic              i_rsp1_ready
);

  logic [1:0]        req_valid;
  logic [1:0]        grant_vec;
  logic              grant_any;
  logic              grant_id;
  logic              rsp_drain;
  logic              slot_free;

  logic              rsp_valid_reg;
  logic              rsp_id_reg;
  logic [DATA_W-1:0] rsp_result_reg;
  logic              ptr_reg;

  assign req_valid = {i_req1_valid, i_req0_valid};

  // Only the owner's response-side ready can drain the slot.
  assign rsp_drain = rsp_valid_reg & (rsp_id_reg ? i_rsp1_ready : i_rsp0_ready);
  assign slot_free = !rsp_valid_reg | rsp_drain;

  always_comb begin
    grant_vec = 2'b00;
    if (!i_rst && slot_free) begin
      case (req_valid)
        2'b01:   grant_vec = 2'b01;
        2'b10:   grant_vec = 2'b10;
        2'b11:   grant_vec = ptr_reg ? 2'b10 : 2'b01;
        default: grant_vec = 2'b00;
      endcase
    end
  end

  assign grant_any    = |grant_vec;
  assign grant_id     = grant_vec[1];
  assign o_req0_ready = grant_vec[0];
  assign o_req1_ready = grant_vec[1];

  // With no grant the select falls back to requester 0; the ALU output is unused then.
  assign o_alu_op1  = grant_id ? i_req1_op1  : i_req0_op1;
  assign o_alu_op2  = grant_id ? i_req1_op2  : i_req0_op2;
  assign o_alu_ctrl = grant_id ? i_req1_ctrl : i_req0_ctrl;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= '0;
      ptr_reg        <= 1'b0;
    end else if (grant_any) begin
      rsp_valid_reg  <= 1'b1;
      rsp_id_reg     <= grant_id;
      rsp_result_reg <= i_alu_result;
      ptr_reg        <= ~grant_id;
    end else if (rsp_drain) begin
      rsp_valid_reg  <= 1'b0;
    end
  end

  assign o_rsp_valid  = rsp_valid_reg;
  assign o_rsp_id     = rsp_id_reg;
  assign o_rsp_result = rsp_result_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU stands in for the
// datapath and a queue of expected responses is checked as they appear.
module tb_alu_arbiter;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam logic [CTRL_W-1:0] C_ADD = 4'd0;
  localparam logic [CTRL_W-1:0] C_SUB = 4'd1;
  localparam logic [CTRL_W-1:0] C_EQ  = 4'd2;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] res;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [CTRL_W-1:0] req0_ctrl = '0, req1_ctrl = '0;
  logic [DATA_W-1:0] alu_op1, alu_op2, alu_result;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              rsp_valid, rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp0_ready = 1'b0, rsp1_ready = 1'b0;

  int   errors = 0;
  int   checks = 0;
  rsp_t sb[$];
  rsp_t exp_r;

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [CTRL_W-1:0] c);
    case (c)
      C_ADD:   return a + b;
      C_SUB:   return a - b;
      C_EQ:    return (a == b) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op1, alu_op2, alu_ctrl);

  alu_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_op1(req0_op1), .i_req0_op2(req0_op2), .i_req0_ctrl(req0_ctrl),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_op1(req1_op1), .i_req1_op2(req1_op2), .i_req1_ctrl(req1_ctrl),
    .o_alu_op1(alu_op1), .o_alu_op2(alu_op2), .o_alu_ctrl(alu_ctrl),
    .i_alu_result(alu_result),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_result(rsp_result),
    .i_rsp0_ready(rsp0_ready), .i_rsp1_ready(rsp1_ready)
  );

  task automatic set_req(input int idx, input logic v, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [CTRL_W-1:0] c);
    if (idx == 0) begin
      req0_valid = v; req0_op1 = a; req0_op2 = b; req0_ctrl = c;
    end else begin
      req1_valid = v; req1_op1 = a; req1_op2 = b; req1_ctrl = c;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== '0) begin
      errors++;
      $display("FAIL reset_rsp: got v=%b id=%b res=%0d, expected v=0 id=0 res=0", rsp_valid, rsp_id, rsp_result);
    end
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b, expected 00", {req1_ready, req0_ready});
    end
    $display("reset: rsp_valid=%b readys=%b", rsp_valid, {req1_ready, req0_ready});
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 32'd5, 32'd3, C_ADD);
    rsp0_ready = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL single_grant: got %b, expected 01", {req1_ready, req0_ready});
    end
    sb.push_back('{1'b0, 32'd8});
    @(posedge clk); #1;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL single_rsp: scoreboard empty");
    end else begin
      exp_r = sb.pop_front();
      $display("single: rsp id=%0d result=%0d", rsp_id, rsp_result);
      if (rsp_valid !== 1'b1 || rsp_id !== exp_r.id || rsp_result !== exp_r.res) begin
        errors++;
        $display("FAIL single_rsp: got v=%b id=%b res=%0d, expected v=1 id=%b res=%0d", rsp_valid, rsp_id, rsp_result, exp_r.id, exp_r.res);
      end
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got v=%b, expected v=0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    do_reset();
    set_req(0, 1'b1, 32'd10, 32'd4, C_SUB);
    set_req(1, 1'b1, 32'd7, 32'd7, C_EQ);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if ({req1_ready, req0_ready} !== exp_g) begin
        errors++;
        $display("FAIL b2b_grant%0d: got %b, expected %b", i, {req1_ready, req0_ready}, exp_g);
      end
      if (exp_g[0]) sb.push_back('{1'b0, 32'd6});
      else          sb.push_back('{1'b1, 32'd1});
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL b2b_rsp%0d: scoreboard empty", i);
      end else begin
        exp_r = sb.pop_front();
        $display("b2b: rsp id=%0d result=%0d", rsp_id, rsp_result);
        if (rsp_valid !== 1'b1 || rsp_id !== exp_r.id || rsp_result !== exp_r.res) begin
          errors++;
          $display("FAIL b2b_rsp%0d: got v=%b id=%b res=%0d, expected v=1 id=%b res=%0d", i, rsp_valid, rsp_id, rsp_result, exp_r.id, exp_r.res);
        end
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 1'b1, 32'd1, 32'd2, C_ADD);
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    #1;
    sb.push_back('{1'b0, 32'd3});
    @(posedge clk); #1;
    @(negedge clk);
    req0_valid = 1'b0;
    set_req(1, 1'b1, 32'd9, 32'd2, C_SUB);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00 || rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd3) begin
        errors++;
        $display("FAIL bp_hold%0d: got readys=%b v=%b id=%b res=%0d, expected readys=00 v=1 id=0 res=3", i, {req1_ready, req0_ready}, rsp_valid, rsp_id, rsp_result);
      end
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++; $display("FAIL bp_refill: got %b, expected 10", {req1_ready, req0_ready});
    end
    void'(sb.pop_front());
    sb.push_back('{1'b1, 32'd7});
    @(posedge clk); #1;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL bp_rsp: scoreboard empty");
    end else begin
      exp_r = sb.pop_front();
      $display("bp: rsp id=%0d result=%0d", rsp_id, rsp_result);
      if (rsp_valid !== 1'b1 || rsp_id !== exp_r.id || rsp_result !== exp_r.res) begin
        errors++;
        $display("FAIL bp_rsp: got v=%b id=%b res=%0d, expected v=1 id=%b res=%0d", rsp_valid, rsp_id, rsp_result, exp_r.id, exp_r.res);
      end
    end
    @(negedge clk);
    req1_valid = 1'b0;
  endtask

  task automatic test_lone();
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      set_req(1, 1'b1, DATA_W'(i), 32'd3, C_EQ);
      if (i == 4) set_req(0, 1'b1, 32'd10, 32'd4, C_SUB);
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== ((i == 4) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL lone_grant%0d: got %b, expected %b", i, {req1_ready, req0_ready}, (i == 4) ? 2'b01 : 2'b10);
      end
      if (i == 4) sb.push_back('{1'b0, 32'd6});
      else        sb.push_back('{1'b1, alu_f(DATA_W'(i), 32'd3, C_EQ)});
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL lone_rsp%0d: scoreboard empty", i);
      end else begin
        exp_r = sb.pop_front();
        $display("lone: rsp id=%0d result=%0d", rsp_id, rsp_result);
        if (rsp_valid !== 1'b1 || rsp_id !== exp_r.id || rsp_result !== exp_r.res) begin
          errors++;
          $display("FAIL lone_rsp%0d: got v=%b id=%b res=%0d, expected v=1 id=%b res=%0d", i, rsp_valid, rsp_id, rsp_result, exp_r.id, exp_r.res);
        end
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_withdraw();
    do_reset();
    set_req(1, 1'b1, 32'd2, 32'd2, C_ADD);
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    #1;
    @(posedge clk); #1;
    @(negedge clk);
    req1_valid = 1'b0;
    set_req(0, 1'b1, 32'd100, 32'd1, C_ADD);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL wd_busy: got %b, expected 00", {req1_ready, req0_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd4) begin
      errors++;
      $display("FAIL wd_nocapture: got v=%b id=%b res=%0d, expected v=1 id=1 res=4", rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clk);
    set_req(0, 1'b1, 32'd100, 32'd1, C_ADD);
    set_req(1, 1'b1, 32'd8, 32'd3, C_SUB);
    rsp1_ready = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL wd_pointer: got %b, expected 01", {req1_ready, req0_ready});
    end
    sb.push_back('{1'b0, 32'd101});
    @(posedge clk); #1;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL wd_rsp: scoreboard empty");
    end else begin
      exp_r = sb.pop_front();
      $display("wd: rsp id=%0d result=%0d", rsp_id, rsp_result);
      if (rsp_valid !== 1'b1 || rsp_id !== exp_r.id || rsp_result !== exp_r.res) begin
        errors++;
        $display("FAIL wd_rsp: got v=%b id=%b res=%0d, expected v=1 id=%b res=%0d", rsp_valid, rsp_id, rsp_result, exp_r.id, exp_r.res);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd1, C_ADD);
    set_req(1, 1'b1, 32'd1, 32'd1, C_ADD);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || {req1_ready, req0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_pre: got v=%b readys=%b, expected v=1 readys=00", rsp_valid, {req1_ready, req0_ready});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== '0 || rsp_id !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_async: got v=%b id=%b res=%0d readys=%b, expected v=0 id=0 res=0 readys=00", rsp_valid, rsp_id, rsp_result, {req1_ready, req0_ready});
    end
    $display("reset_mid: rsp_valid=%b result=%0d", rsp_valid, rsp_result);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_lone();
    test_withdraw();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
